// File: rtl/sha256_stream_core_if.sv
// rtl/sha256_stream_core_if.sv - block-in / digest-out handshake bundle for sha256_stream_core
interface sha256_stream_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] msg;
  logic [1:0]   chain_sel;
  logic [255:0] hin;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] digest;
  logic         busy;

  modport master (
    output in_valid, msg, chain_sel, hin, out_ready,
    input  in_ready, out_valid, digest, busy
  );

  modport slave (
    input  in_valid, msg, chain_sel, hin, out_ready,
    output in_ready, out_valid, digest, busy
  );
endinterface

// File: rtl/sha256_stream_core.sv
// rtl/sha256_stream_core.sv - SHA-256 compression engine, ROUNDS_PER_CYCLE unrolled rounds per clock
module sha256_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic                 clk,
  input logic                 reset_n,
  sha256_stream_core_if.slave bus
);
  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
    $fatal(1, "sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [1:0] {IDLE, COMPUTE, FINAL, OUT} state_t;

  state_t       state;
  logic [31:0]  w     [16];
  logic [31:0]  chain [8];
  logic [31:0]  v     [8];
  logic [6:0]   t;
  logic [255:0] digest_q;
  logic         out_valid_q;
  logic [31:0]  w_nxt [16];
  logic [31:0]  v_nxt [8];
  logic [255:0] chain_in;
  logic         accept;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.in_ready  = (state == IDLE) | ((state == OUT) & bus.out_ready);
  assign bus.busy      = (state == COMPUTE) | (state == FINAL);
  assign bus.out_valid = out_valid_q;
  assign bus.digest    = digest_q;

  always_comb begin
    case (bus.chain_sel)
      2'd1:    chain_in = digest_q;
      2'd2:    chain_in = bus.hin;
      default: chain_in = IV;
    endcase
  end

  // ext[0] is W[t]; the R new words may depend on each other, so they are built in order.
  always_comb begin : p_rounds
    logic [31:0] ext [16 + R];
    logic [31:0] s   [8];
    logic [31:0] t1;
    logic [31:0] t2;
    for (int i = 0; i < 16; i++) ext[i] = w[i];
    for (int j = 0; j < R; j++)
      ext[16 + j] = ssig1(ext[14 + j]) + ext[9 + j] + ssig0(ext[1 + j]) + ext[j];
    for (int i = 0; i < 16; i++) w_nxt[i] = ext[i + R];
    for (int i = 0; i < 8; i++) s[i] = v[i];
    for (int j = 0; j < R; j++) begin
      t1 = s[7] + bsig1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + K[t[5:0] + 6'(j)] + ext[j];
      t2 = bsig0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      s[7] = s[6];
      s[6] = s[5];
      s[5] = s[4];
      s[4] = s[3] + t1;
      s[3] = s[2];
      s[2] = s[1];
      s[1] = s[0];
      s[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) v_nxt[i] = s[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      digest_q    <= '0;
      t           <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        chain[i] <= '0;
        v[i]     <= '0;
      end
    end else begin
      case (state)
        COMPUTE: begin
          for (int i = 0; i < 16; i++) w[i] <= w_nxt[i];
          for (int i = 0; i < 8; i++) v[i] <= v_nxt[i];
          t <= t + 7'(R);
          if (t + 7'(R) == 7'd64) state <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) digest_q[255 - 32*i -: 32] <= chain[i] + v[i];
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        default: begin
          if (state == OUT && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
          // chain_in reads digest_q before this edge updates anything, so a handoff
          // edge can chain straight from the digest being consumed.
          if (accept) begin
            for (int i = 0; i < 16; i++) w[i] <= bus.msg[511 - 32*i -: 32];
            for (int i = 0; i < 8; i++) begin
              chain[i] <= chain_in[255 - 32*i -: 32];
              v[i]     <= chain_in[255 - 32*i -: 32];
            end
            t     <= '0;
            state <= COMPUTE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_stream_core.sv
// tb/tb_sha256_stream_core.sv - scoreboard bench for sha256_stream_core against a plain SHA-256 model
module tb_sha256_stream_core;
  localparam int R   = 4;
  localparam int LAT = 64 / R + 1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] B2 = {480'h0, 32'h000001c0};

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;
  logic [255:0] last_dig = '0;
  logic [255:0] exp_q [$];
  int           acc_q [$];
  logic         ov_prev = 1'b0;
  int           mon_a;
  logic [255:0] mon_e;

  sha256_stream_core_if bus ();

  sha256_stream_core #(.ROUNDS_PER_CYCLE(R)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word schedule first, then 64 rounds.
  function automatic logic [255:0] compress(input logic [255:0] hv, input logic [511:0] m);
    logic [31:0] ww [64];
    logic [31:0] hh [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) ww[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      ww[i] = (ror(ww[i-2], 17) ^ ror(ww[i-2], 19) ^ (ww[i-2] >> 10)) + ww[i-7]
            + (ror(ww[i-15], 7) ^ ror(ww[i-15], 18) ^ (ww[i-15] >> 3)) + ww[i-16];
    for (int i = 0; i < 8; i++) hh[i] = hv[255 - 32*i -: 32];
    a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3]; e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + ww[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hh[0] + a, hh[1] + b, hh[2] + c, hh[3] + d, hh[4] + e, hh[5] + f, hh[6] + g, hh[7] + h};
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [255:0] rand_h();
    logic [255:0] x;
    for (int i = 0; i < 8; i++) x[32*i +: 32] = $urandom;
    return x;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Holds the block until accepted; the expected digest is queued at the accept.
  task automatic send(input logic [511:0] m, input logic [1:0] sel, input logic [255:0] h,
                      output int acc);
    logic [255:0] ch;
    int n;
    n = 0;
    bus.msg = m;
    bus.chain_sel = sel;
    bus.hin = h;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      acc = -1;
    end else begin
      ch = (sel == 2'd1) ? last_dig : (sel == 2'd2) ? h : IV;
      last_dig = compress(ch, m);
      exp_q.push_back(last_dig);
      acc = cyc + 1;
      acc_q.push_back(acc);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_outstanding", 256'(exp_q.size()), 256'd0);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Monitor: latency on each out_valid rise, digest on each handoff.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.out_valid && !ov_prev) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_out_valid", 256'd1, 256'd0);
        end else begin
          mon_a = acc_q.pop_front();
          chk("latency", 256'(cyc - mon_a), 256'(LAT));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_digest", 256'd1, 256'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("digest", bus.digest, mon_e);
        end
      end
    end
    ov_prev = reset_n ? bus.out_valid : 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, n;
    logic [255:0] d0;
    logic stable;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.msg = '0;
    bus.chain_sel = 2'd0;
    bus.hin = '0;

    chk("model_abc", compress(IV, ABC),
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    chk("model_empty", compress(IV, EMPTY),
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
    chk("model_two_block", compress(compress(IV, B1), B2),
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 256'(bus.out_valid), 256'd0);
    chk("reset_digest", bus.digest, 256'd0);
    chk("reset_busy", 256'(bus.busy), 256'd0);
    chk("reset_in_ready", 256'(bus.in_ready), 256'd1);
    reset_n = 1'b1;

    send(ABC, 2'd0, '0, a1);
    drain();
    send(EMPTY, 2'd0, '0, a1);
    drain();

    send(B1, 2'd0, '0, a1);
    send(B2, 2'd1, '0, a2);
    chk("zero_bubble_gap", 256'(a2 - a1), 256'(LAT + 1));
    drain();

    send(ABC, 2'd2, IV, a1);
    drain();

    rdy_mode = 2;
    send(ABC, 2'd3, rand_h(), a1);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 256'(bus.out_valid), 256'd1);
    d0 = bus.digest;
    stable = 1'b1;
    bus.in_valid = 1'b1;
    bus.msg = EMPTY;
    repeat (20) begin
      @(negedge clk);
      if (bus.digest !== d0 || !bus.out_valid || bus.in_ready || bus.busy) stable = 1'b0;
    end
    chk("bp_hold_stable", 256'(stable), 256'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rdy_mode = 0;
    drain();

    send(rand_blk(), 2'd0, '0, a1);
    repeat (30 / R) @(posedge clk);
    #3;
    chk("mid_compute_busy", 256'(bus.busy), 256'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 256'(bus.out_valid), 256'd0);
    chk("async_reset_digest", bus.digest, 256'd0);
    chk("async_reset_in_ready", 256'(bus.in_ready), 256'd1);
    chk("async_reset_busy", 256'(bus.busy), 256'd0);
    exp_q.delete();
    acc_q.delete();
    last_dig = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send(rand_blk(), 2'd1, '0, a1);
    drain();
    send(ABC, 2'd0, '0, a1);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(rand_blk(), 2'($urandom_range(0, 3)), rand_h(), a1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
